// File: rtl/coin_walk_counter.sv
// coin_walk_counter: registered position stepping by STEP_A/STEP_B (coin ^ parity), with
// wrap/saturate modes, IDLE/RUN/SAT FSM and streak detector. Define COINTOSS_HIST_EN for hist.
module coin_walk_counter #(
  parameter int WIDTH      = 3,
  parameter int STEP_A     = 1,
  parameter int STEP_B     = 2,
  parameter int STREAK_W   = 4,
  parameter int STREAK_MAX = 3,
  parameter int HIST_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                toss,
  input  logic                mode,
  input  logic                clr,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  output logic [WIDTH-1:0]    out,
  output logic                wrapped,
  output logic                sat,
  output logic [STREAK_W-1:0] streak,
  output logic                streak_hit
`ifdef COINTOSS_HIST_EN
  ,
  output logic [HIST_DEPTH-1:0] hist
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAT  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0]    POS_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]      STEP_A_X   = (WIDTH+1)'(STEP_A);
  localparam logic [WIDTH:0]      STEP_B_X   = (WIDTH+1)'(STEP_B);
  localparam logic [STREAK_W-1:0] STREAK_TOP = {STREAK_W{1'b1}};
  localparam logic [STREAK_W-1:0] STREAK_HIT = STREAK_W'(STREAK_MAX);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                wrapped_q, wrapped_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                streak_hit_q, streak_hit_d;
  logic                last_toss_q, last_toss_d;

  logic                sel;
  logic [WIDTH:0]      sum;
  logic                carry;
  logic                step_taken;
  logic                streak_grew;

  // Step selection uses the registered position, so parity is that of the current out.
  assign sel   = toss ^ out_q[0];
  assign sum   = {1'b0, out_q} + (sel ? STEP_A_X : STEP_B_X);
  assign carry = sum[WIDTH];

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    out_d        = out_q;
    wrapped_d    = 1'b0;
    step_taken   = 1'b0;

    if (clr) begin
      state_d = ST_IDLE;
      out_d   = '0;
    end else if (load) begin
      state_d = ST_RUN;
      out_d   = load_val;
    end else if (en && state_q != ST_SAT) begin
      step_taken = 1'b1;
      if (carry && mode) begin
        state_d = ST_SAT;
        out_d   = POS_MAX;
      end else begin
        state_d   = ST_RUN;
        out_d     = sum[WIDTH-1:0];
        wrapped_d = carry;
      end
    end
  end

  // Streak only moves on applied steps; a held count at the top does not re-fire the hit.
  always_comb begin
    streak_d     = streak_q;
    last_toss_d  = last_toss_q;
    streak_hit_d = 1'b0;
    streak_grew  = 1'b0;

    if (clr) begin
      streak_d = '0;
    end else if (step_taken) begin
      last_toss_d = toss;
      if (streak_q == '0 || toss != last_toss_q) begin
        streak_d    = STREAK_W'(1);
        streak_grew = 1'b1;
      end else if (streak_q != STREAK_TOP) begin
        streak_d    = streak_q + 1'b1;
        streak_grew = 1'b1;
      end
      streak_hit_d = streak_grew && (streak_d == STREAK_HIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_q        <= '0;
      wrapped_q    <= 1'b0;
      streak_q     <= '0;
      streak_hit_q <= 1'b0;
      last_toss_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q      <= state_d;
      out_q        <= out_d;
      wrapped_q    <= wrapped_d;
      streak_q     <= streak_d;
      streak_hit_q <= streak_hit_d;
      last_toss_q  <= last_toss_d;
    end
  end

  assign out        = out_q;
  assign wrapped    = wrapped_q;
  assign sat        = (state_q == ST_SAT);
  assign streak     = streak_q;
  assign streak_hit = streak_hit_q;

`ifdef COINTOSS_HIST_EN
  logic [HIST_DEPTH-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clr) begin
      hist_d = '0;
    end else if (step_taken) begin
      hist_d = (hist_q << 1) | HIST_DEPTH'(toss);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign hist = hist_q;
`endif

endmodule
